// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 matrix keypad encoder.
package keypad_pkg;

   // Scanner FSM states.
   typedef enum logic [1:0] {
      SCAN    = 2'd0,
      CONFIRM = 2'd1,
      HELD    = 2'd2,
      RELEASE = 2'd3
   } state_t;

   // Column drive after reset: column 0 active (active-low).
   localparam logic [3:0] COL_INIT = 4'b1110;

   // Key codes indexed by {row, col}. '*' encodes as 4'hE and '#' as 4'hF.
   localparam logic [3:0] KEYMAP [16] = '{
      4'h1, 4'h2, 4'h3, 4'hA,
      4'h4, 4'h5, 4'h6, 4'hB,
      4'h7, 4'h8, 4'h9, 4'hC,
      4'hE, 4'h0, 4'hF, 4'hD
   };

   // Index of the lowest zero bit of an active-low 4-bit vector (3 if none below).
   function automatic logic [1:0] first_low(input logic [3:0] v);
      logic [1:0] idx;
      idx = 2'd3;
      for (int i = 3; i >= 0; i--) begin
         if (!v[i]) idx = 2'(i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous inputs; resets to all-ones (idle rows).
module sync_2ff #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] meta;

   // Two-stage capture of the asynchronous input.
   // NOTE: both stages take non-blocking assignments so d reaches q only after two edges;
   // blocking assignments here would collapse the chain into a single flop.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         meta <= '1;
         q    <= '1;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/keypad_encoder.sv
// 4x4 active-low keypad scanner with debounce and a valid/ack handshake.
module keypad_encoder
   import keypad_pkg::*;
#(
   parameter int SCAN_DIV       = 50000,
   parameter int DEBOUNCE_SCANS = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] row_i,
   output logic [3:0] col_o,
   output logic [3:0] key_code,
   output logic       key_valid,
   input  logic       key_ack,
   output logic       key_held,
   output logic       overrun
);

   localparam int SLOT_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int MATCH_W = $clog2(DEBOUNCE_SCANS + 1);

   localparam logic [SLOT_W-1:0]  SLOT_LAST  = SLOT_W'(SCAN_DIV - 1);
   localparam logic [MATCH_W-1:0] MATCH_LAST = MATCH_W'(DEBOUNCE_SCANS - 1);

   logic [3:0]         rs;
   logic [SLOT_W-1:0]  slot_cnt;
   logic               sample;
   state_t             state, state_next;
   logic [MATCH_W-1:0] match_cnt, match_next;
   logic [1:0]         row_sel, row_sel_next;
   logic               row_low;
   logic               rotate;
   logic               accept;
   logic [3:0]         key_idx;

   sync_2ff #(.WIDTH(4)) u_row_sync (
      .clk (clk),
      .rst (rst),
      .d   (row_i),
      .q   (rs)
   );

   assign sample   = (slot_cnt == SLOT_LAST);
   assign row_low  = ~rs[row_sel];
   assign key_held = (state == HELD) || (state == RELEASE);
   // Column is frozen outside SCAN, so the live drive identifies the locked key's column.
   assign key_idx  = {row_sel, first_low(col_o)};

   // Free-running slot counter; wraps at the sample point.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)         slot_cnt <= '0;
      else if (sample) slot_cnt <= '0;
      else             slot_cnt <= slot_cnt + 1'b1;
   end

   // FSM state, match counter and latched row.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= SCAN;
         match_cnt <= '0;
         row_sel   <= 2'd0;
      end else begin
         state     <= state_next;
         match_cnt <= match_next;
         row_sel   <= row_sel_next;
      end
   end

   // Next-state logic; all decisions happen on sample cycles only.
   always_comb begin
      // NOTE: every signal gets a default before the case so no path leaves it unassigned
      // and infers a latch.
      state_next   = state;
      match_next   = match_cnt;
      row_sel_next = row_sel;
      rotate       = 1'b0;
      accept       = 1'b0;
      if (sample) begin
         unique case (state)
            SCAN: begin
               if (rs == 4'hF) begin
                  rotate = 1'b1;
               end else begin
                  row_sel_next = first_low(rs);
                  match_next   = MATCH_W'(1);
                  state_next   = CONFIRM;
               end
            end
            CONFIRM: begin
               if (!row_low) begin
                  state_next = SCAN;
                  match_next = '0;
                  rotate     = 1'b1;
               end else if (match_cnt >= MATCH_LAST) begin
                  state_next = HELD;
                  match_next = '0;
                  accept     = 1'b1;
               end else begin
                  match_next = match_cnt + 1'b1;
               end
            end
            HELD: begin
               if (!row_low) begin
                  state_next = RELEASE;
                  match_next = MATCH_W'(1);
               end
            end
            RELEASE: begin
               if (row_low) begin
                  state_next = HELD;
                  match_next = '0;
               end else if (match_cnt >= MATCH_LAST) begin
                  state_next = SCAN;
                  match_next = '0;
                  rotate     = 1'b1;
               end else begin
                  match_next = match_cnt + 1'b1;
               end
            end
            default: state_next = SCAN;
         endcase
      end
   end

   // Column rotator: one active-low column, moving left on each idle sample.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)         col_o <= COL_INIT;
      else if (rotate) col_o <= {col_o[2:0], col_o[3]};
   end

   // Output code and handshake; a fresh accept takes priority over an ack on the same edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         key_code  <= 4'h0;
         key_valid <= 1'b0;
         overrun   <= 1'b0;
      end else if (accept) begin
         key_code  <= KEYMAP[key_idx];
         key_valid <= 1'b1;
         if (key_valid) overrun <= 1'b1;
      end else if (key_ack && key_valid) begin
         key_valid <= 1'b0;
         overrun   <= 1'b0;
      end
   end

endmodule

// File: tb/tb_keypad_encoder.sv
// Directed bench for keypad_encoder with SCAN_DIV=4, DEBOUNCE_SCANS=3.
module tb_keypad_encoder;

   logic        clk;
   logic        rst;
   logic [3:0]  row_i;
   logic [3:0]  col_o;
   logic [3:0]  key_code;
   logic        key_valid;
   logic        key_ack;
   logic        key_held;
   logic        overrun;
   logic [15:0] pressed;   // bit r*4+c set while key (row r, col c) is down

   int cmp_count = 0;
   int err_count = 0;

   keypad_encoder #(.SCAN_DIV(4), .DEBOUNCE_SCANS(3)) dut (
      .clk       (clk),
      .rst       (rst),
      .row_i     (row_i),
      .col_o     (col_o),
      .key_code  (key_code),
      .key_valid (key_valid),
      .key_ack   (key_ack),
      .key_held  (key_held),
      .overrun   (overrun)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Passive keypad: a pressed key pulls its row low while its column is driven low.
   always_comb begin
      row_i = 4'hF;
      for (int r = 0; r < 4; r++) begin
         for (int c = 0; c < 4; c++) begin
            if (pressed[r*4+c] && !col_o[c]) row_i[r] = 1'b0;
         end
      end
   end

   task automatic wait_valid(input int max, output int n);
      n = 0;
      while (!key_valid && n < max) begin
         @(negedge clk);
         n++;
      end
      if (!key_valid) n = -1;
   endtask

   task automatic wait_held_low(input int max, output int n);
      n = 0;
      while (key_held && n < max) begin
         @(negedge clk);
         n++;
      end
      if (key_held) n = -1;
   endtask

   task automatic pulse_ack();
      key_ack = 1'b1;
      @(negedge clk);
      key_ack = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; key_ack = 1'b0; pressed = '0;
      repeat (3) @(negedge clk);
      cmp_count++;
      if ({col_o, key_code, key_valid, key_held, overrun} !== {4'b1110, 4'h0, 3'b000}) begin
         err_count++;
         $display("FAIL reset_values: got col=%b code=%h v=%b h=%b o=%b, want col=1110 code=0 v=0 h=0 o=0",
                  col_o, key_code, key_valid, key_held, overrun);
      end
      rst = 1'b0;
   endtask

   task automatic test_scan();
      logic [3:0] exp_col [5] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111, 4'b1110};
      for (int i = 0; i < 5; i++) begin
         cmp_count++;
         if (col_o !== exp_col[i] || key_valid !== 1'b0) begin
            err_count++;
            $display("FAIL scan_rotate[%0d]: got col=%b v=%b, want col=%b v=0", i, col_o, key_valid, exp_col[i]);
         end
         repeat (4) @(negedge clk);
      end
   endtask

   task automatic test_bounce();
      int n = 0;
      while (col_o == 4'b1110 && n < 40) begin @(negedge clk); n++; end
      while (col_o != 4'b1110 && n < 40) begin @(negedge clk); n++; end
      cmp_count++;
      if (n >= 40) begin
         err_count++;
         $display("FAIL bounce_align: column 0 not reached, col=%b", col_o);
      end
      pressed = 16'h1000;          // '*' row3/col0
      repeat (4) @(negedge clk);   // exactly one sample sees it low
      cmp_count++;
      if (col_o !== 4'b1110) begin
         err_count++;
         $display("FAIL bounce_freeze: got col=%b, want 1110", col_o);
      end
      pressed = '0;
      repeat (4) @(negedge clk);   // next sample sees it high
      cmp_count++;
      if (col_o !== 4'b1101) begin
         err_count++;
         $display("FAIL bounce_rescan: got col=%b, want 1101", col_o);
      end
      repeat (30) @(negedge clk);
      cmp_count++;
      if (key_valid !== 1'b0 || key_held !== 1'b0) begin
         err_count++;
         $display("FAIL bounce_no_key: got v=%b h=%b, want v=0 h=0", key_valid, key_held);
      end
   endtask

   task automatic test_hold_5();
      int n;
      pressed = 16'h0020;          // '5' row1/col1
      wait_valid(31, n);
      cmp_count++;
      if (n < 0 || key_code !== 4'h5 || key_held !== 1'b1 || col_o !== 4'b1101 || overrun !== 1'b0) begin
         err_count++;
         $display("FAIL hold_5: got wait=%0d code=%h h=%b col=%b o=%b, want wait<=31 code=5 h=1 col=1101 o=0",
                  n, key_code, key_held, col_o, overrun);
      end
      repeat (12) @(negedge clk);
      cmp_count++;
      if (col_o !== 4'b1101 || key_valid !== 1'b1) begin
         err_count++;
         $display("FAIL hold_5_frozen: got col=%b v=%b, want col=1101 v=1", col_o, key_valid);
      end
   endtask

   task automatic test_ack_release();
      int n;
      pulse_ack();
      cmp_count++;
      if (key_valid !== 1'b0 || key_held !== 1'b1 || key_code !== 4'h5) begin
         err_count++;
         $display("FAIL ack_clear: got v=%b h=%b code=%h, want v=0 h=1 code=5", key_valid, key_held, key_code);
      end
      pressed = '0;
      repeat (10) @(negedge clk);
      cmp_count++;
      if (key_held !== 1'b1) begin
         err_count++;
         $display("FAIL release_debounce: got h=%b after 10 clk, want h=1", key_held);
      end
      wait_held_low(20, n);
      cmp_count++;
      if (n < 0 || col_o !== 4'b1011 || key_valid !== 1'b0) begin
         err_count++;
         $display("FAIL release_rescan: got wait=%0d col=%b v=%b, want held low col=1011 v=0", n, col_o, key_valid);
      end
   endtask

   task automatic test_overrun();
      int n;
      pressed = 16'h0400;          // '9' row2/col2
      wait_valid(40, n);
      cmp_count++;
      if (n < 0 || key_code !== 4'h9 || overrun !== 1'b0) begin
         err_count++;
         $display("FAIL press_9: got wait=%0d code=%h o=%b, want code=9 o=0", n, key_code, overrun);
      end
      pressed = '0;
      wait_held_low(40, n);
      pressed = 16'h4000;          // '#' row3/col2
      n = 0;
      while (key_code != 4'hF && n < 40) begin @(negedge clk); n++; end
      cmp_count++;
      if (key_code !== 4'hF || key_valid !== 1'b1 || overrun !== 1'b1) begin
         err_count++;
         $display("FAIL overrun_set: got code=%h v=%b o=%b, want code=F v=1 o=1", key_code, key_valid, overrun);
      end
      pulse_ack();
      cmp_count++;
      if (key_valid !== 1'b0 || overrun !== 1'b0) begin
         err_count++;
         $display("FAIL overrun_ack: got v=%b o=%b, want v=0 o=0", key_valid, overrun);
      end
      pressed = '0;
      wait_held_low(40, n);
   endtask

   task automatic test_multi_key();
      int n;
      pressed = 16'h0404;          // '3' row0/col2 and '9' row2/col2
      wait_valid(40, n);
      cmp_count++;
      if (n < 0 || key_code !== 4'h3) begin
         err_count++;
         $display("FAIL multi_key: got wait=%0d code=%h, want code=3", n, key_code);
      end
      pulse_ack();
      pressed = '0;
      wait_held_low(40, n);
      cmp_count++;
      if (n < 0 || key_valid !== 1'b0) begin
         err_count++;
         $display("FAIL multi_release: got wait=%0d v=%b, want held low v=0", n, key_valid);
      end
   endtask

   task automatic test_reset_mid_press();
      int n;
      pressed = 16'h2000;          // '0' row3/col1
      wait_valid(40, n);
      cmp_count++;
      if (n < 0 || key_code !== 4'h0 || key_held !== 1'b1) begin
         err_count++;
         $display("FAIL press_0: got wait=%0d code=%h h=%b, want code=0 h=1", n, key_code, key_held);
      end
      #2 rst = 1'b1;
      #1;
      cmp_count++;
      if ({col_o, key_code, key_valid, key_held, overrun} !== {4'b1110, 4'h0, 3'b000}) begin
         err_count++;
         $display("FAIL reset_async: got col=%b code=%h v=%b h=%b o=%b, want col=1110 code=0 v=0 h=0 o=0",
                  col_o, key_code, key_valid, key_held, overrun);
      end
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      wait_valid(40, n);
      cmp_count++;
      if (n < 0 || key_code !== 4'h0 || key_held !== 1'b1 || col_o !== 4'b1101) begin
         err_count++;
         $display("FAIL redetect_0: got wait=%0d code=%h h=%b col=%b, want code=0 h=1 col=1101",
                  n, key_code, key_held, col_o);
      end
      pulse_ack();
      pressed = '0;
      wait_held_low(40, n);
   endtask

   initial begin
      test_reset();
      test_scan();
      test_bounce();
      test_hold_5();
      test_ack_release();
      test_overrun();
      test_multi_key();
      test_reset_mid_press();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_count, err_count);
      $finish;
   end

endmodule
